vga_sync_gen: RTL and testbench

Generates 640x480@60 Hz VGA timing from `sys_clk` and drives the pixel coordinates consumed by the pixel generator. It drives `x`, `y` and `video_on` into the pixel generator and takes back its combinational `rgb`. It registers that colour together with delayed `hsync`/`vsync`, so all signals at the VGA connector are pixel-aligned. It is the source end of the pixel-generator interface and the only block that drives the VGA port pins.

---
 rtl/vga_timing_pkg.sv | 17 +
 rtl/vga_pixel_tick.sv | 16 +
 rtl/vga_sync_gen.sv | 94 +++++++++
 tb/tb_vga_sync_gen.sv | 129 ++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 Hz timing constants and default widths shared by
// the sync generator and the pixel generator.
package vga_timing_pkg;
   localparam int VGA_H_DISPLAY = 640;
   localparam int VGA_H_FRONT   = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BACK    = 48;
   localparam int VGA_V_DISPLAY = 480;
   localparam int VGA_V_FRONT   = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BACK    = 33;
   localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
   localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
   localparam int DEF_PIXEL_WIDTH  = 12;
   localparam int DEF_SCREEN_WIDTH = 10;
   localparam logic [11:0] BLACK = 12'h000;
endpackage

// File: rtl/vga_pixel_tick.sv
// vga_pixel_tick: divides the system clock by CLK_DIV and strobes on the last
// system cycle of each pixel period (constantly high when CLK_DIV is 1).
module vga_pixel_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic pixel_tick_o
);
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
   logic [DW-1:0] div_q, div_d;
   assign pixel_tick_o = (div_q == LAST);
   always_comb div_d = pixel_tick_o ? '0 : div_q + 1'b1;
   always_ff @(posedge clk_i) div_q <= rst_i ? '0 : div_d;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing counters plus pixel-aligned colour/sync output stage.
// Define VGA_FRAME_CNT_EN to build the frame counter; otherwise frame_cnt is 0.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV      = 4,
   parameter int H_DISPLAY    = VGA_H_DISPLAY,
   parameter int H_FRONT      = VGA_H_FRONT,
   parameter int H_SYNC       = VGA_H_SYNC,
   parameter int H_BACK       = VGA_H_BACK,
   parameter int V_DISPLAY    = VGA_V_DISPLAY,
   parameter int V_FRONT      = VGA_V_FRONT,
   parameter int V_SYNC       = VGA_V_SYNC,
   parameter int V_BACK       = VGA_V_BACK,
   parameter int SCREEN_WIDTH = DEF_SCREEN_WIDTH,
   parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   output logic [SCREEN_WIDTH-1:0] x,
   output logic [SCREEN_WIDTH-1:0] y,
   output logic                    video_on,
   output logic                    pixel_tick,
   output logic                    frame_start,
   input  logic [PIXEL_WIDTH-1:0]  rgb,
   output logic [PIXEL_WIDTH-1:0]  vga_rgb,
   output logic                    hsync,
   output logic                    vsync,
   output logic [15:0]             frame_cnt
);
   localparam int SW = SCREEN_WIDTH;
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam logic [SW-1:0] H_LAST = SW'(H_TOTAL - 1);
   localparam logic [SW-1:0] V_LAST = SW'(V_TOTAL - 1);
   // Region bounds carry one extra bit so a sync end equal to 2^SW still fits.
   localparam logic [SW:0] H_VIS = (SW+1)'(H_DISPLAY);
   localparam logic [SW:0] HS_LO = (SW+1)'(H_DISPLAY + H_FRONT);
   localparam logic [SW:0] HS_HI = (SW+1)'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [SW:0] V_VIS = (SW+1)'(V_DISPLAY);
   localparam logic [SW:0] VS_LO = (SW+1)'(V_DISPLAY + V_FRONT);
   localparam logic [SW:0] VS_HI = (SW+1)'(V_DISPLAY + V_FRONT + V_SYNC);
   logic                   tick, h_wrap, v_wrap;
   logic [SW:0]            h_ext, v_ext;
   logic [SW-1:0]          h_q, h_d, v_q, v_d;
   logic [PIXEL_WIDTH-1:0] rgb_q, rgb_d;
   logic                   hs_q, hs_d, vs_q, vs_d;
   vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk_i       (sys_clk),
      .rst_i       (sys_rst),
      .pixel_tick_o(tick)
   );
   always_comb begin
      h_wrap   = h_q == H_LAST;
      v_wrap   = v_q == V_LAST;
      h_ext    = {1'b0, h_q};
      v_ext    = {1'b0, v_q};
      video_on = (h_ext < H_VIS) && (v_ext < V_VIS);
      h_d      = !tick ? h_q : h_wrap ? '0 : h_q + 1'b1;
      v_d      = !(tick && h_wrap) ? v_q : v_wrap ? '0 : v_q + 1'b1;
      rgb_d    = !tick ? rgb_q : video_on ? rgb : PIXEL_WIDTH'(BLACK);
      hs_d     = !tick ? hs_q : !((h_ext >= HS_LO) && (h_ext < HS_HI));
      vs_d     = !tick ? vs_q : !((v_ext >= VS_LO) && (v_ext < VS_HI));
   end
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         h_q   <= '0;
         v_q   <= '0;
         rgb_q <= '0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
      end else begin
         h_q   <= h_d;
         v_q   <= v_d;
         rgb_q <= rgb_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
      end
   end
   assign x           = h_q;
   assign y           = v_q;
   assign pixel_tick  = tick;
   assign frame_start = tick & h_wrap & v_wrap;
   assign vga_rgb     = rgb_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] fc_q;
   always_ff @(posedge sys_clk) fc_q <= sys_rst ? '0 : fc_q + 16'(frame_start);
   assign frame_cnt = fc_q;
`else
   assign frame_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks on a full-size 640x480 instance (reset, one
// line, mid-line reset) and on a tiny-timing instance (whole frames, vsync, frame_cnt).
module tb_vga_sync_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;
   logic        rst_a, rst_b;
   logic [11:0] rgb = 12'hABC;
   logic [9:0]  a_x, a_y, b_x, b_y;
   logic        a_von, a_pt, a_fs, a_hs, a_vs, b_von, b_pt, b_fs, b_hs, b_vs;
   logic [11:0] a_rgb, b_rgb;
   logic [15:0] a_fc, b_fc;
   vga_sync_gen dut (
      .sys_clk(clk), .sys_rst(rst_a), .x(a_x), .y(a_y), .video_on(a_von),
      .pixel_tick(a_pt), .frame_start(a_fs), .rgb(rgb), .vga_rgb(a_rgb),
      .hsync(a_hs), .vsync(a_vs), .frame_cnt(a_fc)
   );
   // 15x10 frame, hsync over x 10..12, vsync over y 7..8, two clocks per pixel
   vga_sync_gen #(
      .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
   ) dut_s (
      .sys_clk(clk), .sys_rst(rst_b), .x(b_x), .y(b_y), .video_on(b_von),
      .pixel_tick(b_pt), .frame_start(b_fs), .rgb(rgb), .vga_rgb(b_rgb),
      .hsync(b_hs), .vsync(b_vs), .frame_cnt(b_fc)
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   initial begin
      int fall = 0, low = 0, tk = 0, nfs = 0, vfall = 0, vrise = 0, fs1 = 0, fs2 = 0, exp_fc;
      logic prev_h, pt, pvs, fs;
`ifdef VGA_FRAME_CNT_EN
      exp_fc = 3;
`else
      exp_fc = 0;
`endif
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (3) step();
      check("rst_x", 32'(a_x), 0);
      check("rst_y", 32'(a_y), 0);
      check("rst_hsync", 32'(a_hs), 1);
      check("rst_vsync", 32'(a_vs), 1);
      check("rst_rgb", 32'(a_rgb), 0);
      check("rst_video_on", 32'(a_von), 1);
      check("rst_tick", 32'(a_pt), 0);
      check("rst_frame_start", 32'(a_fs), 0);
      check("rst_frame_cnt", 32'(a_fc), 0);
      rst_a = 1'b0;
      repeat (2) step();
      check("tick_early", 32'(a_pt), 0);
      step();
      check("first_tick", 32'(a_pt), 1);
      check("first_tick_x", 32'(a_x), 0);
      step();
      check("x_after_tick", 32'(a_x), 1);
      check("tick_clear", 32'(a_pt), 0);
      check("rgb_px0", 32'(a_rgb), 32'h0ABC);
      for (int n = 2; n <= 800; n++) begin
         prev_h = a_hs;
         repeat (4) step();
         if (prev_h && !a_hs) fall = n;
         if (!a_hs) low++;
         if (n == 640) check("rgb_px639", 32'(a_rgb), 32'h0ABC);
         if (n == 641) check("rgb_px640_blank", 32'(a_rgb), 0);
         if (n == 641) check("video_off_x641", 32'(a_von), 0);
         if (n == 799) check("x_799", 32'(a_x), 799);
         if (n == 799) check("y_before_wrap", 32'(a_y), 0);
      end
      check("x_wrap", 32'(a_x), 0);
      check("y_wrap", 32'(a_y), 1);
      check("hsync_fall_tick", 32'(fall), 657);
      check("hsync_low_ticks", 32'(low), 96);
      repeat (700 * 4) step();
      check("pre_rst_x", 32'(a_x), 700);
      check("pre_rst_hsync", 32'(a_hs), 0);
      rst_a = 1'b1;
      step();
      rst_a = 1'b0;
      check("midrst_x", 32'(a_x), 0);
      check("midrst_y", 32'(a_y), 0);
      check("midrst_hsync", 32'(a_hs), 1);
      check("midrst_vsync", 32'(a_vs), 1);
      check("midrst_rgb", 32'(a_rgb), 0);
      check("midrst_tick", 32'(a_pt), 0);
      repeat (4) step();
      check("restart_x", 32'(a_x), 1);
      check("restart_y", 32'(a_y), 0);
      rst_b = 1'b0;
      for (int c = 0; c < 1000 && nfs < 3; c++) begin
         pt = b_pt;
         pvs = b_vs;
         fs = b_fs;
         step();
         if (pt) tk++;
         if (fs) begin
            nfs++;
            if (nfs == 1) fs1 = tk;
            if (nfs == 2) fs2 = tk;
         end
         if (pvs && !b_vs && vfall == 0) vfall = tk;
         if (!pvs && b_vs && vfall != 0 && vrise == 0) vrise = tk;
         if (pt && tk == 76) check("s_rgb_y5_visible", 32'(b_rgb), 32'h0ABC);
         if (pt && tk == 91) check("s_rgb_y6_blank", 32'(b_rgb), 0);
         if (pt && tk == 91) check("s_video_off_y6", 32'(b_von), 0);
         if (pt && tk == 50) check("s_frame_cnt_mid", 32'(b_fc), 0);
      end
      check("s_frame_starts", 32'(nfs), 3);
      check("s_first_frame_start", 32'(fs1), 150);
      check("s_frame_period", 32'(fs2 - fs1), 150);
      check("s_vsync_fall", 32'(vfall), 106);
      check("s_vsync_low", 32'(vrise - vfall), 30);
      check("s_wrap_x", 32'(b_x), 0);
      check("s_wrap_y", 32'(b_y), 0);
      check("s_frame_cnt", 32'(b_fc), 32'(exp_fc));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
